// File: rtl/geffe_word_packer.sv
// Packs the serial Geffe keystream (LSB-first) into WORD_W-bit words and queues them in a small FIFO.
// Optional repetition-count health test compiled in with `define HEALTH_TEST_EN.
module geffe_word_packer #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int RUN_MAX    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_in,
    input  logic                          bit_en,
    input  logic                          clear,
    output logic [WORD_W-1:0]             word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          health_fail
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WORD_W);

    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] assembled;
    logic [BW-1:0]     bitcnt;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              accept;
    logic              word_done;
    logic              full;
    logic              pop;
    logic              push;

`ifdef HEALTH_TEST_EN
    logic [7:0] runcnt;
    logic [7:0] run_next;
    logic       lastbit;
    logic       fail_q;

    // A clear in the same cycle unblocks the strobe and restarts the run at this bit.
    always_comb begin
        accept = bit_en & (~fail_q | clear);
        if (clear || bit_in != lastbit) begin
            run_next = 8'd1;
        end else if (runcnt == 8'hFF) begin
            run_next = runcnt;
        end else begin
            run_next = runcnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            runcnt  <= 8'd0;
            lastbit <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            if (clear) begin
                runcnt <= 8'd0;
                fail_q <= 1'b0;
            end
            if (accept) begin
                runcnt  <= run_next;
                lastbit <= bit_in;
                if (run_next == 8'(RUN_MAX)) begin
                    fail_q <= 1'b1;
                end
            end
        end
    end

    assign health_fail = fail_q;
`else
    assign accept      = bit_en;
    assign health_fail = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        assembled         = shreg;
        assembled[bitcnt] = bit_in;
    end

    assign word_done  = accept && (bitcnt == BW'(WORD_W - 1));
    assign full       = (count == CW'(FIFO_DEPTH));
    assign word_valid = (count != '0);
    assign pop        = word_valid & word_ready;
    assign push       = word_done & (~full | pop);
    assign word_out   = word_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (accept) begin
            shreg  <= word_done ? '0 : assembled;
            bitcnt <= word_done ? '0 : bitcnt + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (clear) begin
                overflow <= 1'b0;
            end
            if (word_done && full && !pop) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: word storage has no reset; the count gates word_out, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= assembled;
        end
    end

endmodule

// File: tb/tb_geffe_word_packer.sv
// Self-checking bench for geffe_word_packer: vector table, hand-written corner sequences,
// and a queue scoreboard that checks every delivered word.
module tb_geffe_word_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_en;
    logic       clear;
    logic [7:0] word_out;
    logic       word_valid;
    logic       word_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       health_fail;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [0:7] seq;   // send order, left to right
        int         gap;   // idle cycles after each bit
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[4];

    geffe_word_packer #(.WORD_W(8), .FIFO_DEPTH(4), .RUN_MAX(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_en     (bit_en),
        .clear      (clear),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        bit_en = 1'b0;
        clear  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Scoreboard: compare each transfer against the oldest expected word.
    always @(negedge clk) begin
        if (rst && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_word: got %0h expected none", word_out);
            end else begin
                check("word_out", word_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{seq: 8'b1010_1010, gap: 1, exp: 8'h55};
        vecs[1] = '{seq: 8'b1111_0000, gap: 0, exp: 8'h0F};
        vecs[2] = '{seq: 8'b0000_0001, gap: 2, exp: 8'h80};
        vecs[3] = '{seq: 8'b0110_0101, gap: 0, exp: 8'hA6};

        bit_in     = 1'b0;
        word_ready = 1'b1;
        do_reset();
        check("rst_valid", word_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_health", health_fail, 0);
        check("rst_word", word_out, 0);

        // First word: 1,0,1,1,0,0,1,0 -> 8'h4D, valid for exactly one cycle.
        exp_q.push_back(8'h4D);
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        send_bit(0); send_bit(0); send_bit(1);
        check("valid_before_last", word_valid, 0);
        send_bit(0);
        check("valid_after_last", word_valid, 1);
        check("word_4d", word_out, 8'h4D);
        tick();
        check("valid_one_cycle", word_valid, 0);

        // Vector table, disabled cycles drive the opposite bit.
        foreach (vecs[k]) begin
            exp_q.push_back(vecs[k].exp);
            for (int i = 0; i < 8; i++) begin
                send_bit(vecs[k].seq[i]);
                for (int g = 0; g < vecs[k].gap; g++) begin
                    bit_in = ~vecs[k].seq[i];
                    tick();
                end
            end
            tick();
        end
        check("table_drained", exp_q.size(), 0);

        // Overflow: five words into a four-entry FIFO with no consumer.
        word_ready = 1'b0;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
        check("full_count", fifo_count, 4);
        check("full_no_ovf", overflow, 0);
        send_word(8'h55);
        check("ovf_count", fifo_count, 4);
        check("ovf_set", overflow, 1);
        check("stable_head", word_out, 8'h11);
        word_ready = 1'b1;
        repeat (6) tick();
        check("ovf_drained_count", fifo_count, 0);
        check("ovf_drained_q", exp_q.size(), 0);
        check("ovf_sticky", overflow, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full FIFO, pop on the same edge that completes the next word.
        word_ready = 1'b0;
        exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
        exp_q.push_back(8'hD4); exp_q.push_back(8'hE5);
        send_word(8'hA1); send_word(8'hB2); send_word(8'hC3); send_word(8'hD4);
        for (int i = 0; i < 7; i++) send_bit(8'hE5 >> i);
        word_ready = 1'b1;
        send_bit(1'b1);
        check("pushpop_count", fifo_count, 4);
        check("pushpop_no_ovf", overflow, 0);
        repeat (6) tick();
        check("pushpop_drained", exp_q.size(), 0);

        // Reset mid-word with two words queued.
        word_ready = 1'b0;
        send_word(8'h3C); send_word(8'hC3);
        send_bit(1); send_bit(1); send_bit(1);
        check("pre_rst_count", fifo_count, 2);
        rst = 1'b0;
        tick();
        check("midrst_valid", word_valid, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_word", word_out, 0);
        check("midrst_ovf", overflow, 0);
        rst        = 1'b1;
        word_ready = 1'b1;
        exp_q.push_back(8'h96);
        send_word(8'h96);
        repeat (2) tick();
        check("fresh_word_q", exp_q.size(), 0);

        // Health test: sixteen consecutive ones after reset.
        do_reset();
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        for (int i = 1; i <= 16; i++) begin
            send_bit(1'b1);
            if (i == 15) check("health_at_15", health_fail, 0);
        end
`ifdef HEALTH_TEST_EN
        check("health_at_16", health_fail, 1);
`else
        check("health_at_16", health_fail, 0);
        exp_q.push_back(8'hFF);
`endif
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        repeat (2) tick();
        check("health_words", exp_q.size(), 0);
        check("health_count", fifo_count, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("health_cleared", health_fail, 0);
        exp_q.push_back(8'h5A);
        send_word(8'h5A);
        repeat (2) tick();
        check("resume_word_q", exp_q.size(), 0);
        check("resume_health", health_fail, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
